// File: rtl/debounce_pkg.sv
// Shared FSM type and sizing helpers for the shared-counter button debouncer.
package debounce_pkg;

  typedef enum logic {IDLE, TIMING} deb_state_t;

  localparam int unsigned MIN_CNT_W = 1;

  function automatic int unsigned stable_cycles(input int unsigned clk_freq,
                                                input int unsigned stable_time);
    longint unsigned prod;
    prod = 64'(clk_freq) * 64'(stable_time) / 64'd1000;
    return 32'(prod);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? 32'($clog2(cycles)) : MIN_CNT_W;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit, async active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_arbiter.sv
// Debounces NUM_BTN buttons through one round-robin-granted stable-time counter.
// Optional DEBOUNCE_RELEASE_PULSE_EN adds a release_pulse output (1->0 acceptance).
module debounce_arbiter
  import debounce_pkg::*;
#(
  parameter  int unsigned NUM_BTN     = 4,
  parameter  int unsigned clk_freq    = 100_000_000,
  parameter  int unsigned stable_time = 50,
  localparam int unsigned CH_W        = $clog2(NUM_BTN)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] button,
  output logic [NUM_BTN-1:0] result,
  output logic [NUM_BTN-1:0] press_pulse,
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  output logic [NUM_BTN-1:0] release_pulse,
`endif
  output logic               busy,
  output logic [CH_W-1:0]    active_ch
);

  localparam int unsigned     STABLE_CYCLES = stable_cycles(clk_freq, stable_time);
  localparam int unsigned     CNT_W         = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(NUM_BTN - 1);

  logic [NUM_BTN-1:0] sync;
  logic [NUM_BTN-1:0] mis;
  deb_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [CH_W-1:0]    rr_ptr;
  logic [CH_W-1:0]    next_ptr;
  logic [CH_W-1:0]    pick;
  logic [CH_W-1:0]    idx;
  logic               found;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_sync
    sync_2ff u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (button[g]),
      .q       (sync[g])
    );
  end

  assign mis      = sync ^ result;
  assign next_ptr = (active_ch == CH_LAST) ? '0 : active_ch + 1'b1;

  // First mismatching channel at or after rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      idx = CH_W'((32'(rr_ptr) + i) % NUM_BTN);
      if (!found && mis[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      active_ch     <= '0;
      cnt           <= '0;
      rr_ptr        <= '0;
      result        <= '0;
      press_pulse   <= '0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      release_pulse <= '0;
`endif
    end else begin
      press_pulse   <= '0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      release_pulse <= '0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            active_ch <= pick;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= TIMING;
          end
        end
        TIMING: begin
          if (!mis[active_ch]) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end else if (cnt == CNT_LAST) begin
            result[active_ch]        <= ~result[active_ch];
            press_pulse[active_ch]   <= ~result[active_ch];
`ifdef DEBOUNCE_RELEASE_PULSE_EN
            release_pulse[active_ch] <= result[active_ch];
`endif
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
